// File: rtl/trap_seq.sv
// Trap-entry / mret sequencer: serialises machine-mode CSR updates onto the
// CSR file's single write port, arbitrates W-stage CSR writes and issues the redirect.
module trap_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            exc_valid,
    input  logic            exc_interrupt,
    input  logic [4:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    input  logic            w_valid,
    input  logic [11:0]     w_addr,
    input  logic [XLEN-1:0] w_data,
    output logic            w_ready,
    input  logic [XLEN-1:0] mstatus_in,
    input  logic [XLEN-1:0] mtvec_in,
    input  logic [XLEN-1:0] mepc_in,
    output logic            csr_valid,
    output logic [11:0]     csr_wa,
    output logic [XLEN-1:0] csr_wd,
    output logic            busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    typedef enum logic [2:0] {
        IDLE,
        T_MEPC,
        T_MCAUSE,
        T_MTVAL,
        T_MSTATUS,
        M_MSTATUS,
        REDIRECT
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] tval_q;
    logic [XLEN-1:0] mstatus_q;
    logic [XLEN-1:0] target_q;
    logic            intr_q;
    logic [4:0]      code_q;

    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] trap_mstatus;
    logic [XLEN-1:0] mret_mstatus;

    // Vectored mode only applies to interrupts; the add wraps naturally at XLEN bits.
    always_comb begin
        tvec_base   = {mtvec_in[XLEN-1:2], 2'b00};
        trap_target = tvec_base;
        if (mtvec_in[1:0] == 2'b01 && exc_interrupt)
            trap_target = tvec_base + XLEN'({exc_code, 2'b00});
    end

    always_comb begin
        trap_mstatus        = mstatus_q;
        trap_mstatus[7]     = mstatus_q[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;
        mret_mstatus        = mstatus_q;
        mret_mstatus[3]     = mstatus_q[7];
        mret_mstatus[7]     = 1'b1;
        mret_mstatus[12:11] = 2'b11;
    end

    // CSR-file inputs are sampled only in the accept cycle so our own writes never feed back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc_q      <= '0;
            tval_q    <= '0;
            mstatus_q <= '0;
            target_q  <= '0;
            intr_q    <= 1'b0;
            code_q    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (exc_valid) begin
                    pc_q      <= exc_pc;
                    tval_q    <= exc_tval;
                    intr_q    <= exc_interrupt;
                    code_q    <= exc_code;
                    mstatus_q <= mstatus_in;
                    target_q  <= trap_target;
                end else if (mret_valid) begin
                    mstatus_q <= mstatus_in;
                    target_q  <= mepc_in;
                end
            end
        end
    end

    always_comb begin
        state_next     = state;
        w_ready        = 1'b0;
        csr_valid      = 1'b0;
        csr_wa         = '0;
        csr_wd         = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        busy           = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (exc_valid) begin
                    state_next = T_MEPC;
                end else if (mret_valid) begin
                    state_next = M_MSTATUS;
                end else if (w_valid) begin
                    w_ready   = 1'b1;
                    csr_valid = 1'b1;
                    csr_wa    = w_addr;
                    csr_wd    = w_data;
                end
            end
            T_MEPC: begin
                csr_valid  = 1'b1;
                csr_wa     = ADDR_MEPC;
                csr_wd     = {pc_q[XLEN-1:2], 2'b00};
                state_next = T_MCAUSE;
            end
            T_MCAUSE: begin
                csr_valid  = 1'b1;
                csr_wa     = ADDR_MCAUSE;
                csr_wd     = {intr_q, {(XLEN-6){1'b0}}, code_q};
                state_next = T_MTVAL;
            end
            T_MTVAL: begin
                csr_valid  = 1'b1;
                csr_wa     = ADDR_MTVAL;
                csr_wd     = tval_q;
                state_next = T_MSTATUS;
            end
            T_MSTATUS: begin
                csr_valid  = 1'b1;
                csr_wa     = ADDR_MSTATUS;
                csr_wd     = trap_mstatus;
                state_next = REDIRECT;
            end
            M_MSTATUS: begin
                csr_valid  = 1'b1;
                csr_wa     = ADDR_MSTATUS;
                csr_wd     = mret_mstatus;
                state_next = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_seq.sv
// Self-checking bench for trap_seq: directed scenarios plus randomized
// trap/mret/write traffic against a cycle-level behavioural model.
module tb_trap_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid;
    logic        exc_interrupt;
    logic [4:0]  exc_code;
    logic [63:0] exc_pc;
    logic [63:0] exc_tval;
    logic        mret_valid;
    logic        w_valid;
    logic [11:0] w_addr;
    logic [63:0] w_data;
    logic        w_ready;
    logic [63:0] mstatus_in;
    logic [63:0] mtvec_in;
    logic [63:0] mepc_in;
    logic        csr_valid;
    logic [11:0] csr_wa;
    logic [63:0] csr_wd;
    logic        busy;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          v;
        logic [11:0] wa;
        logic [63:0] wd;
        bit          rv;
        logic [63:0] rpc;
    } exp_t;

    trap_seq #(.XLEN(64)) dut (
        .clk(clk),
        .reset(reset),
        .exc_valid(exc_valid),
        .exc_interrupt(exc_interrupt),
        .exc_code(exc_code),
        .exc_pc(exc_pc),
        .exc_tval(exc_tval),
        .mret_valid(mret_valid),
        .w_valid(w_valid),
        .w_addr(w_addr),
        .w_data(w_data),
        .w_ready(w_ready),
        .mstatus_in(mstatus_in),
        .mtvec_in(mtvec_in),
        .mepc_in(mepc_in),
        .csr_valid(csr_valid),
        .csr_wa(csr_wa),
        .csr_wd(csr_wd),
        .busy(busy),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // Reference rules, written as plain arithmetic on the architectural fields.
    function automatic logic [63:0] model_mcause(bit intr, logic [4:0] code);
        return (intr ? 64'h8000_0000_0000_0000 : 64'd0) + 64'(code);
    endfunction

    function automatic logic [63:0] model_trap_mstatus(logic [63:0] m);
        logic [63:0] mie;
        mie = (m >> 3) & 64'd1;
        return (m & ~64'h1888) | (mie << 7) | 64'h1800;
    endfunction

    function automatic logic [63:0] model_mret_mstatus(logic [63:0] m);
        logic [63:0] mpie;
        mpie = (m >> 7) & 64'd1;
        return (m & ~64'h1888) | (mpie << 3) | 64'h0080 | 64'h1800;
    endfunction

    function automatic logic [63:0] model_target(logic [63:0] tvec, bit intr, logic [4:0] code);
        logic [63:0] base;
        base = tvec - (tvec % 4);
        if ((tvec % 4) == 1 && intr)
            return base + 64'(code) * 4;
        return base;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        exc_valid     = 1'b0;
        exc_interrupt = 1'b0;
        exc_code      = '0;
        exc_pc        = '0;
        exc_tval      = '0;
        mret_valid    = 1'b0;
        w_valid       = 1'b0;
        w_addr        = '0;
        w_data        = '0;
        mstatus_in    = '0;
        mtvec_in      = '0;
        mepc_in       = '0;
    endtask

    task automatic scramble_csr_inputs();
        exc_pc     = {$urandom, $urandom};
        exc_tval   = {$urandom, $urandom};
        exc_code   = 5'($urandom);
        mstatus_in = {$urandom, $urandom};
        mtvec_in   = {$urandom, $urandom};
        mepc_in    = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
        checks++; if (csr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_csr_valid got %0b want 0", csr_valid); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_redirect got %0b want 0", redirect_valid); end
        checks++; if (redirect_pc !== 64'd0) begin errors++; $display("[TB] FAIL reset_redirect_pc got %h want 0", redirect_pc); end
        checks++; if (csr_wa !== 12'd0 || csr_wd !== 64'd0) begin errors++; $display("[TB] FAIL reset_wa_wd got %h/%h want 0/0", csr_wa, csr_wd); end
        checks++; if (w_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_w_ready got %0b want 0", w_ready); end
        reset = 1'b0;
        tick();
        #1;
        checks++; if (busy !== 1'b0 || csr_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle got busy=%0b csr_valid=%0b want 0/0", busy, csr_valid); end
    endtask

    task automatic test_plain_exception();
        logic [11:0] wa_exp [4];
        logic [63:0] wd_exp [4];
        wa_exp = '{12'h341, 12'h342, 12'h343, 12'h300};
        wd_exp = '{64'h8000_0104, 64'h2, 64'h13, 64'h1880};
        tick();
        clear_inputs();
        exc_valid  = 1'b1;
        exc_code   = 5'd2;
        exc_pc     = 64'h8000_0104;
        exc_tval   = 64'h13;
        mstatus_in = 64'h8;
        mtvec_in   = 64'h8000_0000;
        #1;
        checks++; if (busy !== 1'b0 || csr_valid !== 1'b0) begin errors++; $display("[TB] FAIL exc_accept got busy=%0b csr_valid=%0b want 0/0", busy, csr_valid); end
        for (int c = 1; c <= 6; c++) begin
            tick();
            scramble_csr_inputs();
            if (c == 6) exc_valid = 1'b0;
            #1;
            if (c <= 4) begin
                checks++; if (csr_valid !== 1'b1 || csr_wa !== wa_exp[c-1] || csr_wd !== wd_exp[c-1])
                    begin errors++; $display("[TB] FAIL exc_write_c%0d got v=%0b %h<-%h want 1 %h<-%h", c, csr_valid, csr_wa, csr_wd, wa_exp[c-1], wd_exp[c-1]); end
                checks++; if (busy !== 1'b1 || redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL exc_busy_c%0d got busy=%0b rv=%0b want 1/0", c, busy, redirect_valid); end
            end else if (c == 5) begin
                checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0000 || csr_valid !== 1'b0)
                    begin errors++; $display("[TB] FAIL exc_redirect got rv=%0b pc=%h v=%0b want 1 80000000 0", redirect_valid, redirect_pc, csr_valid); end
                checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL exc_busy_c5 got %0b want 1", busy); end
            end else begin
                checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0 || csr_valid !== 1'b0)
                    begin errors++; $display("[TB] FAIL exc_return_idle got busy=%0b rv=%0b v=%0b want 0/0/0", busy, redirect_valid, csr_valid); end
            end
        end
        clear_inputs();
    endtask

    task automatic test_vectored_interrupt();
        tick();
        clear_inputs();
        exc_valid     = 1'b1;
        exc_interrupt = 1'b1;
        exc_code      = 5'd7;
        exc_pc        = 64'h8000_0107;
        exc_tval      = 64'h0;
        mstatus_in    = 64'h0;
        mtvec_in      = 64'h8000_0001;
        for (int c = 1; c <= 6; c++) begin
            tick();
            scramble_csr_inputs();
            if (c == 6) exc_valid = 1'b0;
            #1;
            if (c == 1) begin
                checks++; if (csr_wa !== 12'h341 || csr_wd !== 64'h8000_0104) begin errors++; $display("[TB] FAIL vec_mepc_align got %h<-%h want 341<-80000104", csr_wa, csr_wd); end
            end
            if (c == 2) begin
                checks++; if (csr_wa !== 12'h342 || csr_wd !== 64'h8000_0000_0000_0007) begin errors++; $display("[TB] FAIL vec_mcause got %h<-%h want 342<-8000000000000007", csr_wa, csr_wd); end
            end
            if (c == 4) begin
                checks++; if (csr_wa !== 12'h300 || csr_wd !== 64'h1800) begin errors++; $display("[TB] FAIL vec_mstatus got %h<-%h want 300<-1800", csr_wa, csr_wd); end
            end
            if (c == 5) begin
                checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_001C) begin errors++; $display("[TB] FAIL vec_redirect got rv=%0b pc=%h want 1 8000001c", redirect_valid, redirect_pc); end
            end
        end
        clear_inputs();
    endtask

    task automatic test_mret();
        tick();
        clear_inputs();
        mret_valid = 1'b1;
        mstatus_in = 64'h80;
        mepc_in    = 64'h8000_0200;
        #1;
        checks++; if (busy !== 1'b0 || csr_valid !== 1'b0) begin errors++; $display("[TB] FAIL mret_accept got busy=%0b v=%0b want 0/0", busy, csr_valid); end
        tick();
        scramble_csr_inputs();
        mret_valid = 1'b0;
        #1;
        checks++; if (csr_valid !== 1'b1 || csr_wa !== 12'h300 || csr_wd !== 64'h1888 || busy !== 1'b1)
            begin errors++; $display("[TB] FAIL mret_mstatus got v=%0b %h<-%h busy=%0b want 1 300<-1888 1", csr_valid, csr_wa, csr_wd, busy); end
        tick();
        scramble_csr_inputs();
        #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0200 || csr_valid !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("[TB] FAIL mret_redirect got rv=%0b pc=%h v=%0b busy=%0b want 1 80000200 0 1", redirect_valid, redirect_pc, csr_valid, busy); end
        tick();
        #1;
        checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL mret_return_idle got busy=%0b rv=%0b want 0/0", busy, redirect_valid); end
        clear_inputs();
    endtask

    task automatic test_write_passthrough();
        tick();
        clear_inputs();
        w_valid = 1'b1;
        w_addr  = 12'h340;
        w_data  = 64'h55;
        #1;
        checks++; if (w_ready !== 1'b1 || csr_valid !== 1'b1 || csr_wa !== 12'h340 || csr_wd !== 64'h55)
            begin errors++; $display("[TB] FAIL passthrough got rdy=%0b v=%0b %h<-%h want 1 1 340<-55", w_ready, csr_valid, csr_wa, csr_wd); end
        tick();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL passthrough_no_busy got %0b want 0", busy); end
        clear_inputs();
    endtask

    task automatic test_arbitration();
        tick();
        clear_inputs();
        exc_valid = 1'b1;
        exc_code  = 5'd11;
        exc_pc    = 64'h1000;
        mtvec_in  = 64'h2000;
        w_valid   = 1'b1;
        w_addr    = 12'h340;
        w_data    = 64'h55;
        #1;
        checks++; if (w_ready !== 1'b0 || csr_valid !== 1'b0) begin errors++; $display("[TB] FAIL arb_exc_drop got rdy=%0b v=%0b want 0/0", w_ready, csr_valid); end
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 6) exc_valid = 1'b0;
            #1;
            if (c <= 5) begin
                checks++; if (w_ready !== 1'b0) begin errors++; $display("[TB] FAIL arb_busy_ready_c%0d got %0b want 0", c, w_ready); end
                checks++; if (csr_valid === 1'b1 && csr_wa === 12'h340) begin errors++; $display("[TB] FAIL arb_busy_write_c%0d got %h<-%h want no 340 write", c, csr_wa, csr_wd); end
            end
            if (c == 5) begin
                checks++; if (redirect_pc !== 64'h2000) begin errors++; $display("[TB] FAIL arb_redirect got %h want 2000", redirect_pc); end
            end
            if (c == 6) begin
                checks++; if (w_ready !== 1'b1 || csr_wa !== 12'h340) begin errors++; $display("[TB] FAIL arb_resume got rdy=%0b wa=%h want 1 340", w_ready, csr_wa); end
            end
        end
        tick();
        clear_inputs();
        mret_valid = 1'b1;
        mepc_in    = 64'h3000;
        w_valid    = 1'b1;
        w_addr     = 12'h340;
        #1;
        checks++; if (w_ready !== 1'b0 || csr_valid !== 1'b0) begin errors++; $display("[TB] FAIL arb_mret_drop got rdy=%0b v=%0b want 0/0", w_ready, csr_valid); end
        tick();
        mret_valid = 1'b0;
        #1;
        checks++; if (w_ready !== 1'b0 || csr_wa !== 12'h300) begin errors++; $display("[TB] FAIL arb_mret_write got rdy=%0b wa=%h want 0 300", w_ready, csr_wa); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_trap();
        tick();
        clear_inputs();
        exc_valid = 1'b1;
        exc_pc    = 64'h4000;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exc_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (csr_valid !== 1'b0 || redirect_valid !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("[TB] FAIL reset_mid_trap_c%0d got v=%0b rv=%0b busy=%0b want 0/0/0", c, csr_valid, redirect_valid, busy); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        tick();
        clear_inputs();
        exc_valid = 1'b1;
        exc_pc    = 64'hA000;
        mtvec_in  = 64'h100;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 5) begin
                exc_pc   = 64'hB004;
                exc_code = 5'd3;
                mtvec_in = 64'h204;
            end
            if (c == 11) exc_valid = 1'b0;
            #1;
            if (c == 6) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_c6 got busy=%0b want 0", busy); end
            end
            if (c == 7) begin
                checks++; if (csr_wa !== 12'h341 || csr_wd !== 64'hB004) begin errors++; $display("[TB] FAIL b2b_second_mepc got %h<-%h want 341<-b004", csr_wa, csr_wd); end
            end
            if (c == 11) begin
                checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h204) begin errors++; $display("[TB] FAIL b2b_second_redirect got rv=%0b pc=%h want 1 204", redirect_valid, redirect_pc); end
            end
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int op;
        bit is_trap;
        bit intr;
        logic [4:0]  code;
        logic [63:0] pc, tval, ms, tvec, epc, target;
        logic [11:0] wa;
        logic [63:0] wd;
        for (int it = 0; it < 80; it++) begin
            op   = $urandom_range(0, 5);
            intr = 1'($urandom);
            code = 5'($urandom);
            pc   = {$urandom, $urandom};
            tval = {$urandom, $urandom};
            ms   = {$urandom, $urandom};
            tvec = {$urandom, $urandom};
            epc  = {$urandom, $urandom};
            wa   = 12'($urandom);
            wd   = {$urandom, $urandom};
            is_trap = (op == 1 || op == 3);
            tick();
            exc_valid     = is_trap;
            mret_valid    = (op == 2 || op == 4) || (is_trap && $urandom_range(0, 1) == 1);
            w_valid       = (op == 0 || op == 3 || op == 4);
            exc_interrupt = intr;
            exc_code      = code;
            exc_pc        = pc;
            exc_tval      = tval;
            mstatus_in    = ms;
            mtvec_in      = tvec;
            mepc_in       = epc;
            w_addr        = wa;
            w_data        = wd;
            #1;
            checks++; if (w_ready !== (op == 0) || csr_valid !== (op == 0))
                begin errors++; $display("[TB] FAIL rnd_accept_it%0d got rdy=%0b v=%0b want %0b", it, w_ready, csr_valid, op == 0); end
            checks++; if (op == 0 && (csr_wa !== wa || csr_wd !== wd))
                begin errors++; $display("[TB] FAIL rnd_pass_it%0d got %h<-%h want %h<-%h", it, csr_wa, csr_wd, wa, wd); end
            checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0)
                begin errors++; $display("[TB] FAIL rnd_idle_it%0d got busy=%0b rv=%0b want 0/0", it, busy, redirect_valid); end
            q = {};
            if (is_trap) begin
                target = model_target(tvec, intr, code);
                q.push_back('{1'b1, 12'h341, pc & ~64'd3, 1'b0, 64'd0});
                q.push_back('{1'b1, 12'h342, model_mcause(intr, code), 1'b0, 64'd0});
                q.push_back('{1'b1, 12'h343, tval, 1'b0, 64'd0});
                q.push_back('{1'b1, 12'h300, model_trap_mstatus(ms), 1'b0, 64'd0});
                q.push_back('{1'b0, 12'h000, 64'd0, 1'b1, target});
            end else if (op == 2 || op == 4) begin
                q.push_back('{1'b1, 12'h300, model_mret_mstatus(ms), 1'b0, 64'd0});
                q.push_back('{1'b0, 12'h000, 64'd0, 1'b1, epc});
            end
            while (q.size() > 0) begin
                e = q.pop_front();
                tick();
                scramble_csr_inputs();
                exc_interrupt = 1'($urandom);
                exc_valid     = is_trap ? 1'b1 : 1'($urandom);
                mret_valid    = 1'($urandom);
                w_valid       = 1'($urandom);
                w_addr        = 12'($urandom);
                w_data        = {$urandom, $urandom};
                #1;
                checks++; if (csr_valid !== e.v || csr_wa !== e.wa || csr_wd !== e.wd)
                    begin errors++; $display("[TB] FAIL rnd_write_it%0d got v=%0b %h<-%h want %0b %h<-%h", it, csr_valid, csr_wa, csr_wd, e.v, e.wa, e.wd); end
                checks++; if (redirect_valid !== e.rv || redirect_pc !== e.rpc)
                    begin errors++; $display("[TB] FAIL rnd_redirect_it%0d got rv=%0b pc=%h want %0b %h", it, redirect_valid, redirect_pc, e.rv, e.rpc); end
                checks++; if (busy !== 1'b1 || w_ready !== 1'b0)
                    begin errors++; $display("[TB] FAIL rnd_busy_it%0d got busy=%0b rdy=%0b want 1/0", it, busy, w_ready); end
            end
            clear_inputs();
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_plain_exception();
        test_vectored_interrupt();
        test_mret();
        test_write_passthrough();
        test_arbitration();
        test_reset_mid_trap();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_seq.md
# trap_seq

Trap and `mret` sequencer for the machine-mode CSR file. It sits between the M/W pipeline stages and the CSR file's single write port (`valid`/`wa`/`wd`). It serialises trap entry (mepc, mcause, mtval, mstatus) and `mret` (mstatus) into one write per cycle. It also arbitrates W-stage CSR-instruction writes onto the same port and issues the pipeline redirect.

## Interface
- `XLEN`, 64, register width; matches `common::XLEN`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `exc_valid`  in  1  M-stage trap request; held by the pipeline until `busy` has risen and fallen.
- `exc_interrupt`  in  1  trap is an interrupt (mcause MSB).
- `exc_code`  in  5  cause code.
- `exc_pc`  in  XLEN  faulting/interrupted PC.
- `exc_tval`  in  XLEN  trap value.
- `mret_valid`  in  1  M-stage `mret`.
- `w_valid`  in  1  W-stage CSR-instruction write request.
- `w_addr`  in  12  CSR address.
- `w_data`  in  XLEN  write data.
- `w_ready`  out  1  W-stage write accepted this cycle.
- `mstatus_in`, `mtvec_in`, `mepc_in`  in  XLEN each  current CSR values, read from the CSR file.
- `csr_valid`  out  1  drives CSR file `valid`.
- `csr_wa`  out  12  drives `wa`.
- `csr_wd`  out  XLEN  drives `wd`.
- `busy`  out  1  stall the pipeline; high whenever state ≠ IDLE.
- `redirect_valid`  out  1  one-cycle redirect/flush pulse.
- `redirect_pc`  out  XLEN  target PC.

## Operation
- **CSR addresses:**
  - MSTATUS 0x300
  - MTVEC 0x305
  - MEPC 0x341
  - MCAUSE 0x342
  - MTVAL 0x343
- **States:** IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, M_MSTATUS, REDIRECT.
- **IDLE priority:** `exc_valid` > `mret_valid` > `w_valid`.
  - **exc_valid:** captures `exc_*` into internal registers, plus `mstatus_in`. Also computes the target from `mtvec_in`. Next state T_MEPC.
  - **mret_valid (no exc):** captures `mstatus_in` and `mepc_in`. Next state M_MSTATUS.
  - **w_valid alone:** combinational pass-through: `csr_valid=1`, `csr_wa=w_addr`, `csr_wd=w_data`, `w_ready=1`.
  - **w_valid with exc or mret in the same cycle:** the write is dropped (`w_ready=0`). It is an older instruction only if the pipeline says so; the pipeline does not assert both for the same instruction.
- **Trap writes**, one per state:
  - T_MEPC writes `exc_pc & ~3`.
  - T_MCAUSE writes `{exc_interrupt, (XLEN-6)'0, exc_code}`.
  - T_MTVAL writes `exc_tval`.
  - T_MSTATUS writes the captured mstatus modified as: bit7 (MPIE) ← bit3 (MIE); bit3 ← 0; bits[12:11] (MPP) ← 2'b11.
  - Then REDIRECT.
- **M_MSTATUS** writes: bit3 ← bit7; bit7 ← 1; bits[12:11] ← 2'b11. Then REDIRECT.
- **Trap target:**
  - base = `mtvec_in & ~3`.
  - If `mtvec_in[1:0]==1` and `exc_interrupt`: target = base + (`exc_code` << 2), modulo 2^XLEN.
  - Otherwise target = base.
- **mret target:** captured `mepc_in`.
- **REDIRECT:** `redirect_valid=1`, `redirect_pc`=target, `csr_valid=0`. Next state IDLE.
- **Inputs ignored outside IDLE:** `exc_valid`, `mret_valid` and `w_valid` are ignored (`w_ready=0`). The pipeline is stalled by `busy`.
- **Idle outputs:** outside the write states and pass-through, `csr_valid=0`, `csr_wa=0`, `csr_wd=0`, `redirect_pc=0`.

## Timing
- **Reset (cycle after reset asserted):** state IDLE; captured registers 0. All outputs are 0, except `w_ready`, which follows the IDLE pass-through rule.
- **Reset mid-sequence:** aborts the sequence; no further writes; no redirect.
- **Trap accepted at cycle 0:**
  - Cycles 1–4: mepc, mcause, mtval, mstatus writes.
  - Cycle 5: redirect.
  - `busy` high cycles 1–5.
  - Cycle 6: IDLE; a new request can be accepted.
- **mret accepted at cycle 0:** cycle 1 mstatus write; cycle 2 redirect; `busy` high cycles 1–2.
- **W-stage write:** zero-latency pass-through; the CSR file updates at the next edge.
- **Back-to-back:** an `exc_valid` still high in cycle 6 is treated as a new trap. The pipeline deasserts it on `redirect_valid`.
- **Sampling:** CSR-file inputs are sampled only in the accept cycle. Sequencer writes do not feed back into the target.

## Test plan
- **Reset mid-trap:** reset at cycle 2 of a trap → no `csr_valid` and no `redirect_valid` afterwards; state IDLE.
- **Plain exception:** `mstatus_in`=0x8, `mtvec_in`=0x8000_0000, `exc_code`=2, `exc_pc`=0x8000_0104, `exc_tval`=0x13. Required:
  - Writes, in order: 0x341←0x8000_0104, 0x342←0x2, 0x343←0x13, 0x300←0x1880.
  - Redirect to 0x8000_0000 at cycle 5.
- **Vectored interrupt:** `mtvec_in`=0x8000_0001, `exc_interrupt`=1, `exc_code`=7 → mcause write 0x8000_0000_0000_0007; `redirect_pc`=0x8000_001C.
- **mret:** `mstatus_in`=0x80, `mepc_in`=0x8000_0200 → 0x300←0x1888 at cycle 1; redirect to 0x8000_0200 at cycle 2.
- **Arbitration:**
  - `w_valid` together with `exc_valid` in IDLE → `w_ready=0`; trap sequence proceeds.
  - `w_valid` during `busy` → `w_ready=0` and no write.
  - Lone `w_valid` to 0x340 with 0x55 → `csr_valid=1`, `csr_wa`=0x340, `csr_wd`=0x55, `w_ready=1`, same cycle.
